uart_rx_oversample: RTL and testbench
=====================================

Name: uart_rx_oversample

Overview:
- 16x-oversampling UART receiver. Consumes the serial line driven by the existing UART transmitter (tx-to-rx loopback at top level) and delivers parallel bytes with a valid/ack handshake.
- Runs entirely on the single system clock (50 MHz, 20 ns period).
- The oversample tick is derived internally, so no separate receive clock is required.
- Performs start-bit validation, 3-sample majority voting per bit, stop-bit checking and overrun detection.

Parameters:
- TICK_DIV, 27, system clocks per oversample tick (50 MHz / (115200 × 16) ≈ 27).
- OS_RATE, 16, oversample ticks per bit; must be even and ≥ 8.
- DATA_BITS, 8, data bits per frame, LSB first; no parity; 1 stop bit.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- rxd  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last good received byte.
- rx_valid  output  1  high while rx_data holds an unacknowledged byte.
- rx_ack  input  1  consumer acknowledge; clears rx_valid.
- frame_err  output  1  one-cycle pulse when a bad stop bit is sampled.
- overrun  output  1  one-cycle pulse when a good byte completes while rx_valid=1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - Synchronizer flops and edge-detect flop are set to 1.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Tick counter, oversample counter and bit index are set to 0.
  - Reset asserted mid-frame abandons the frame and delivers nothing.
- Synchronizer:
  - rxd passes through a 2-flop synchronizer (rxd_s).
  - A third flop (rxd_p) provides edge detection.
  - Falling edge = rxd_p & ~rxd_s.
- Tick generator:
  - Counts 0..TICK_DIV-1.
  - tick=1 for exactly one clock when the count equals TICK_DIV-1, then the count wraps to 0.
  - Cleared to 0 in the clock where a falling edge is detected in IDLE, which phase-aligns ticks to the start edge.
- Oversample counter (os_cnt) increments on each tick within a bit, 0..OS_RATE-1.
- Majority sampling:
  - Samples rxd_s on ticks at os_cnt = OS_RATE/2-1, OS_RATE/2 and OS_RATE/2+1.
  - Bit value = majority of the 3 samples (≥2 ones → 1).
- States:
  - IDLE: busy=0. Falling edge → START, with os_cnt=0.
  - START: at the third sample, majority 1 → false start, return to IDLE with no output. Majority 0 → continue. On the tick at os_cnt=OS_RATE-1 → DATA, with bit_idx=0 and os_cnt=0.
  - DATA: voted bit is shifted into the shift register at position bit_idx (LSB first). At os_cnt=OS_RATE-1: if bit_idx=DATA_BITS-1 → STOP, otherwise bit_idx+1.
  - STOP: decision at the third sample, then → IDLE immediately, mid-stop-bit, which allows back-to-back frames.
    - Stop vote 1 and rx_valid=0: load rx_data and set rx_valid.
    - Stop vote 1 and rx_valid=1: pulse overrun; rx_data is unchanged and the new byte is discarded.
    - Stop vote 0: pulse frame_err; rx_data and rx_valid are unchanged.
- Re-arm: IDLE needs a fresh falling edge. A line held low (break) after a frame error therefore does not retrigger until it returns high.
- Latency: rx_valid and pulses assert in the clock after the tick carrying the third stop sample.
- Handshake:
  - rx_ack=1 with rx_valid=1 clears rx_valid next clock.
  - rx_ack while rx_valid=0 is ignored.
  - If a load and rx_ack occur in the same clock, the load wins: rx_valid stays 1 with the new data. This is not an overrun, because the old byte was acked.

Decomposition:
- Shared uart_defs package/header:
  - State encodings: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Defaults: OS_RATE_DEF=16, TICK_DIV_DEF=27.
  - The transmitter reuses these defaults so TX and RX baud match.
- One sub-module, uart_os_tick: parameterised divider with a synchronous clear input and a tick output.

Test Plan:
- Frame 0xA5 (bit time 432 clk), rx_ack held 0 → rx_valid=1, rx_data=8'hA5, frame_err=0, busy falls at mid-stop-bit.
- rxd low glitch of 100 clk, then high → no rx_valid, busy returns to 0 after the start sample, state IDLE.
- Frame 0x5A with stop bit driven 0 → frame_err pulse of exactly 1 clk, rx_valid stays 0, rx_data unchanged; no new frame until rxd rises and falls again.
- Back-to-back 0x3C then 0xC3, no ack → rx_data=8'h3C, overrun 1-clk pulse at end of second frame; after ack, rx_valid=0.
- rst=1 for 1 clk in the middle of data bit 3 of 0xFF, then a clean 0x81 → no output from the aborted frame, rx_data=8'h81, rx_valid=1.
- Loopback with the existing transmitter sending 0x00, 0xFF, 0x55 with ack after each → three matching bytes, no frame_err/overrun.

Source files
------------

// File: rtl/uart_rx_oversample_pkg.sv
// Shared UART definitions: receiver state encodings, the default baud
// divider settings (also used by the transmitter so both ends run at the
// same rate) and the 3-sample majority vote.
package uart_rx_oversample_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int OS_RATE_DEF  = 16;
   localparam int TICK_DIV_DEF = 27;

   // Two or more ones out of three samples reads as a 1.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick divider. Counts 0..TICK_DIV-1 on the system clock and
// raises tick for the single clock in which the count sits at TICK_DIV-1.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   clr  - synchronous clear; restarts the count to phase-align ticks
//   tick - one-clock pulse every TICK_DIV clocks
module uart_os_tick
   import uart_rx_oversample_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver (8N1 by default, LSB first).
// The serial line is synchronized, the start edge phase-aligns the internal
// oversample tick, and each bit is the majority of three samples taken
// around the bit centre. Completed bytes are handed over with valid/ack.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   rxd       - asynchronous serial input, idles high
//   rx_data   - last good received byte
//   rx_valid  - rx_data holds an unacknowledged byte
//   rx_ack    - consumer acknowledge, clears rx_valid
//   frame_err - one-clock pulse on a bad stop bit
//   overrun   - one-clock pulse when a good byte arrives while rx_valid=1
//   busy      - receiver is inside a frame
module uart_rx_oversample
   import uart_rx_oversample_pkg::*;
#(
   parameter int TICK_DIV  = TICK_DIV_DEF,
   parameter int OS_RATE   = OS_RATE_DEF,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ack,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int OSW = $clog2(OS_RATE);
   localparam int BIW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Sample points straddle the bit centre; LAST closes the bit.
   localparam logic [OSW-1:0] SMP0  = OSW'(OS_RATE/2 - 1);
   localparam logic [OSW-1:0] SMP1  = OSW'(OS_RATE/2);
   localparam logic [OSW-1:0] SMP2  = OSW'(OS_RATE/2 + 1);
   localparam logic [OSW-1:0] LAST  = OSW'(OS_RATE - 1);
   localparam logic [BIW-1:0] BLAST = BIW'(DATA_BITS - 1);

   rx_state_t            state;
   logic                 rxd_m, rxd_s, rxd_p;
   logic                 fall, tick, tick_clr, vote;
   logic [OSW-1:0]       os_cnt;
   logic [BIW-1:0]       bit_idx;
   logic [1:0]           samp;
   logic [DATA_BITS-1:0] shreg;

   // Synchronizer plus edge-detect flop; all idle high so reset never
   // looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
         rxd_p <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
         rxd_p <= rxd_s;
      end
   end

   assign fall     = rxd_p & ~rxd_s;
   assign tick_clr = (state == IDLE) && fall;
   assign vote     = maj3(samp[0], samp[1], rxd_s);

   uart_os_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (tick_clr),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         os_cnt    <= '0;
         bit_idx   <= '0;
         samp      <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         // A load later in this block overrides the clear.
         if (rx_ack && rx_valid)
            rx_valid <= 1'b0;

         if (state == IDLE) begin
            if (fall) begin
               state  <= START;
               os_cnt <= '0;
               busy   <= 1'b1;
            end
         end else if (tick) begin
            os_cnt <= (os_cnt == LAST) ? '0 : os_cnt + 1'b1;
            if (os_cnt == SMP0)
               samp[0] <= rxd_s;
            if (os_cnt == SMP1)
               samp[1] <= rxd_s;

            if (state == START) begin
               if (os_cnt == SMP2 && vote) begin
                  state <= IDLE;   // glitch, not a real start bit
                  busy  <= 1'b0;
               end else if (os_cnt == LAST) begin
                  state   <= DATA;
                  bit_idx <= '0;
               end
            end else if (state == DATA) begin
               if (os_cnt == SMP2)
                  shreg[bit_idx] <= vote;
               if (os_cnt == LAST) begin
                  if (bit_idx == BLAST)
                     state <= STOP;
                  else
                     bit_idx <= bit_idx + 1'b1;
               end
            end else begin
               // Decide mid-stop-bit and drop to IDLE straight away so the
               // next start edge can follow the stop bit immediately.
               if (os_cnt == SMP2) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (!vote)
                     frame_err <= 1'b1;
                  else if (!rx_valid || rx_ack) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end else
                     overrun <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_oversample.sv
module tb_uart_rx_oversample;

   localparam int BT = 27 * 16;   // clocks per bit

   localparam int EV_BYTE = 0;
   localparam int EV_FERR = 1;
   localparam int EV_OVR  = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;   // rx_data expected when the event is seen
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int  passed = 0;
   int  total  = 0;
   ev_t sb[$];
   bit  prev_valid = 1'b0;
   bit  prev_ferr  = 1'b0;
   bit  prev_ovr   = 1'b0;

   always #10 clk = ~clk;

   uart_rx_oversample dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ack    (rx_ack),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic push(input int kind, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic got_event(input int kind);
      ev_t e;
      if (sb.size() == 0)
         chk("sb_unexpected_event", 32'(sb.size()), 1);
      else begin
         e = sb.pop_front();
         chk("ev_kind", 32'(kind), 32'(e.kind));
         chk("ev_rx_data", 32'(rx_data), 32'(e.data));
      end
   endtask

   // Output monitor: every DUT event must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (rx_valid === 1'b1 && !prev_valid)
            got_event(EV_BYTE);
         if (frame_err === 1'b1) begin
            chk("ferr_width", 32'(prev_ferr), 0);
            got_event(EV_FERR);
         end
         if (overrun === 1'b1) begin
            chk("ovr_width", 32'(prev_ovr), 0);
            got_event(EV_OVR);
         end
      end
      prev_valid = (rx_valid === 1'b1);
      prev_ferr  = (frame_err === 1'b1);
      prev_ovr   = (overrun === 1'b1);
   end

   // Start bit plus data bits; caller drives the stop bit.
   task automatic send_body(input logic [7:0] d);
      rxd = 1'b0;
      repeat (BT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         repeat (BT) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stopb);
      send_body(d);
      rxd = stopb;
      repeat (BT) @(negedge clk);
   endtask

   task automatic ack;
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      chk("ack_clears_valid", 32'(rx_valid), 0);
   endtask

   initial begin
      #(90000 * 20);
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] lb [3];
      lb[0] = 8'h00;
      lb[1] = 8'hFF;
      lb[2] = 8'h55;

      rst    = 1'b1;
      rxd    = 1'b1;
      rx_ack = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_rx_data", 32'(rx_data), 0);
      chk("rst_rx_valid", 32'(rx_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      chk("rst_overrun", 32'(overrun), 0);
      repeat (20) @(negedge clk);

      // Frame 0xA5, no ack; busy must drop mid-stop-bit.
      push(EV_BYTE, 8'hA5);
      send_body(8'hA5);
      rxd = 1'b1;
      repeat (200) @(negedge clk);
      chk("a5_busy_early_stop", 32'(busy), 1);
      repeat (100) @(negedge clk);
      chk("a5_busy_mid_stop", 32'(busy), 0);
      chk("a5_valid", 32'(rx_valid), 1);
      chk("a5_data", 32'(rx_data), 32'h A5);
      repeat (BT - 300) @(negedge clk);
      ack();
      repeat (BT) @(negedge clk);

      // 100-clock low glitch: false start.
      rxd = 1'b0;
      repeat (100) @(negedge clk);
      rxd = 1'b1;
      repeat (50) @(negedge clk);
      chk("glitch_busy_during", 32'(busy), 1);
      repeat (400) @(negedge clk);
      chk("glitch_busy_after", 32'(busy), 0);
      chk("glitch_state", 32'(dut.state), 0);
      chk("glitch_valid", 32'(rx_valid), 0);
      repeat (BT) @(negedge clk);

      // Frame 0x5A with a low stop bit, then a held break.
      push(EV_FERR, 8'hA5);
      send_frame(8'h5A, 1'b0);
      repeat (2 * BT) @(negedge clk);
      chk("break_no_retrigger", 32'(busy), 0);
      rxd = 1'b1;
      repeat (BT) @(negedge clk);
      chk("ferr_valid", 32'(rx_valid), 0);
      chk("ferr_data_kept", 32'(rx_data), 32'h A5);

      // Back-to-back 0x3C, 0xC3 with no ack: second byte overruns.
      push(EV_BYTE, 8'h3C);
      push(EV_OVR, 8'h3C);
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      chk("ovr_data", 32'(rx_data), 32'h 3C);
      chk("ovr_valid", 32'(rx_valid), 1);
      ack();
      repeat (BT) @(negedge clk);

      // Reset in the middle of data bit 3 of 0xFF, then a clean 0x81.
      rxd = 1'b0;
      repeat (BT) @(negedge clk);
      rxd = 1'b1;
      repeat (3 * BT + BT / 2) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", 32'(busy), 0);
      repeat (BT / 2 - 1 + 5 * BT) @(negedge clk);
      chk("aborted_valid", 32'(rx_valid), 0);
      push(EV_BYTE, 8'h81);
      send_frame(8'h81, 1'b1);
      chk("post_rst_data", 32'(rx_data), 32'h 81);
      chk("post_rst_valid", 32'(rx_valid), 1);
      ack();
      repeat (BT) @(negedge clk);

      // Transmitter-style loopback of three bytes, ack after each.
      for (int k = 0; k < 3; k++) begin
         push(EV_BYTE, lb[k]);
         send_frame(lb[k], 1'b1);
         chk("loop_data", 32'(rx_data), 32'(lb[k]));
         chk("loop_valid", 32'(rx_valid), 1);
         ack();
      end
      repeat (BT) @(negedge clk);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
